booth_mult_16bit: RTL and testbench

//  Multi-cycle signed multiplier for the execute stage. Sits beside the 16-bit carry-lookahead adder in the ALU.

---
 rtl/alu_pkg.sv | 14 +
 rtl/booth_mult_16bit_if.sv | 21 ++
 rtl/booth_mult_16bit_booth_step.sv | 36 +++
 rtl/booth_mult_16bit.sv | 82 ++++++++
 tb/tb_booth_mult_16bit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: multiplier state encoding, operand width and the
// start-to-done latency the hazard/stall unit budgets for.
package alu_pkg;

    localparam int MUL_WIDTH   = 16;
    localparam int MUL_LATENCY = 17;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/booth_mult_16bit_if.sv
// Multiplier request/result bundle.
//   start  : request a multiply (honoured only when busy=0)
//   A, B   : signed multiplicand / multiplier, captured at the start edge
//   busy   : operation in flight (drives the execute-stage stall)
//   done   : one-cycle pulse, P valid in the same cycle
//   P      : registered signed product, held until the next done
interface booth_mult_16bit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] P;

    modport master (output start, A, B, input  busy, done, P);
    modport slave  (input  start, A, B, output busy, done, P);
endinterface

// File: rtl/booth_mult_16bit_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc_in  : {U[WIDTH:0], L[WIDTH-1:0], q}
//   areg    : captured multiplicand
//   acc_out : accumulator after add/sub on U and a 1-bit arithmetic shift
module booth_step
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH+1:0] acc_in,
    input  logic [WIDTH-1:0]   areg,
    output logic [2*WIDTH+1:0] acc_out
);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   u;
    logic [WIDTH-1:0] l;
    logic             q;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   sum;

    assign {u, l, q} = acc_in;
    // U carries one guard bit so -2^(WIDTH-1) * -2^(WIDTH-1) cannot overflow.
    assign a_ext     = {areg[WIDTH-1], areg};

    always_comb begin
        sum = u;
        unique case ({l[0], q})
            2'b01:   sum = u + a_ext;
            2'b10:   sum = u + ~a_ext + ONE;
            default: sum = u;
        endcase
        // Arithmetic shift: replicate U's MSB, the old L[0] becomes the new q.
        acc_out = {sum[WIDTH], sum, l};
    end
endmodule

// File: rtl/booth_mult_16bit.sv
// Multi-cycle radix-2 Booth signed multiplier for the execute stage.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset; aborts an operation in flight
//   bus : slave side of booth_mult_16bit_if (start/A/B in, busy/done/P out)
// One Booth step per RUN cycle, WIDTH steps per product, then a one-cycle
// DONE that can reload immediately for back-to-back operation.
module booth_mult_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    booth_mult_16bit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    mul_state_e         state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*WIDTH+1:0] acc;
    logic [2*WIDTH+1:0] acc_step;
    logic [WIDTH-1:0]   areg;
    logic [2*WIDTH-1:0] p_q;
    logic               load;
    logic               last;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc),
        .areg    (areg),
        .acc_out (acc_step)
    );

    assign last = (count == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: if (bus.start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                // start in DONE reloads without an idle bubble
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            areg  <= '0;
            p_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                acc   <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
                areg  <= bus.A;
                count <= '0;
            end else if (state == RUN) begin
                acc   <= acc_step;
                count <= count + CW'(1);
                // Product is {U[WIDTH-1:0], L} of the final shifted value.
                if (last) p_q <= acc_step[2*WIDTH:1];
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.P    = p_q;
endmodule

// File: tb/tb_booth_mult_16bit.sv
module tb_booth_mult_16bit;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_mult_16bit_if #(.WIDTH(W)) bus ();
    booth_mult_16bit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        string          name;
    } vec_t;

    vec_t tbl[8];

    // Reference: plain signed arithmetic on the operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // P may only change on the edge that enters DONE or on a reset edge.
    logic [2*W-1:0] p_prev = '0;
    always @(posedge clk) begin
        logic rst_at_edge;
        rst_at_edge = rst;
        #1;
        if (!rst_at_edge && !bus.done && bus.P !== p_prev) begin
            miscompares++;
            $display("FAIL p_stable: got %h expected %h", bus.P, p_prev);
        end
        p_prev = bus.P;
    end

    // Start one op, scramble A/B while it runs, check latency, busy span and product.
    task automatic mul_check(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] exp, input string name, input bit timing);
        int edges, busy_cnt;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 0; busy_cnt = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            bus.A = W'($urandom); bus.B = W'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        if (timing) begin
            chk({name, "_latency"}, 64'(edges), 64'(MUL_LATENCY - 1));
            chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
            chk({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        end
        chk(name, 64'(bus.P), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] a1, b1, a2, b2, ra, rb;
        logic [W-1:0] corners[5];
        int edges, done_seen;

        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        corners[0] = 16'h8000; corners[1] = 16'h7FFF; corners[2] = 16'h0000;
        corners[3] = 16'h0001; corners[4] = 16'hFFFF;

        tbl[0] = '{16'h0003, 16'h0005, 32'h0000_000F, "t1_3x5"};
        tbl[1] = '{16'h8000, 16'h8000, 32'h4000_0000, "t2_min_x_min"};
        tbl[2] = '{16'h7FFF, 16'h8000, 32'hC000_8000, "t3_max_x_min"};
        tbl[3] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "t3_neg1_x_1"};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, "neg1_x_neg1"};
        tbl[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max_x_max"};
        tbl[6] = '{16'h8000, 16'h0001, 32'hFFFF_8000, "min_x_1"};
        tbl[7] = '{16'h0000, 16'h1234, 32'h0000_0000, "zero_x"};

        // Reset state, with start asserted to check reset priority.
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_P",    64'(bus.P),    64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            mul_check(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].name, i == 0);

        // Start held high with changing operands during RUN, then start in DONE.
        a1 = 16'h04D2; b1 = 16'hFDC9; a2 = 16'hABCD; b2 = 16'h1357;
        @(negedge clk);
        bus.A = a1; bus.B = b1; bus.start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            bus.A = W'($urandom); bus.B = W'($urandom);
            @(posedge clk);
        end
        #1;
        chk("b2b_first_done", 64'(bus.done), 64'd1);
        chk("b2b_first_P", 64'(bus.P), 64'(ref_mul(a1, b1)));
        @(negedge clk);
        bus.A = a2; bus.B = b2; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_second_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < 40) begin
            @(posedge clk); #1;
            if (!bus.done) @(negedge clk);
            edges++;
        end
        chk("b2b_second_latency", 64'(edges), 64'(MUL_LATENCY));
        chk("b2b_second_P", 64'(bus.P), 64'(ref_mul(a2, b2)));

        // Reset at RUN step 8 aborts: no done, P cleared.
        @(negedge clk);
        bus.A = 16'h1111; bus.B = 16'h2222; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_P",    64'(bus.P),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        mul_check(16'hF00D, 16'h0BAD, ref_mul(16'hF00D, 16'h0BAD), "after_abort", 1'b1);

        // Randomized operands, biased toward the extremes.
        for (int i = 0; i < 2500; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            mul_check(ra, rb, ref_mul(ra, rb), "random", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
